// File: rtl/hv_gen_sched.sv
// hv_gen_sched: round-robin scheduler sharing one LFSR phase-shifter
// hypervector generator among NUM_REQ clients. It launches a generator run,
// flags the wanted beats of the raw data_stream, and waits for gen_done
// before the next grant.
// Define HVGEN_WDOG_EN to add a watchdog that ends a run whose gen_done
// never arrives and pulses err.
module hv_gen_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned CYCLES     = 625,
`ifdef HVGEN_WDOG_EN
    parameter int unsigned WDOG_SLACK = 8,
`endif
    parameter int unsigned IDX_W      = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] req_len,
    output logic                     gen_initiate,
    input  logic                     gen_done,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     beat_valid,
    output logic [IDX_W-1:0]         beat_idx,
    output logic                     beat_last,
    output logic [NUM_REQ-1:0]       cmpl,
    output logic                     busy,
    output logic                     err
);

    localparam int unsigned      PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] BEATS    = IDX_W'(CYCLES + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_STREAM,
        ST_CMPL
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [IDX_W-1:0]   win_len;
    logic [NUM_REQ-1:0] req_sh;
    int unsigned        cand;

`ifdef HVGEN_WDOG_EN
    localparam int unsigned WDOG_LIM = CYCLES + 2 + WDOG_SLACK;
    localparam int unsigned WDOG_W   = $clog2(WDOG_LIM + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              wdog_fire;
`endif

    // Round-robin pick: first requester at or after the pointer, with its clamped length.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        req_sh    = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand   = (32'(ptr_q) + off) % NUM_REQ;
            req_sh = req >> cand;
            if (!win_found && req_sh[0]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
        win_len = IDX_W'(req_len >> (32'(win_idx) * IDX_W));
        if (win_len > BEATS) begin
            win_len = BEATS;
        end
    end

    // Next-state logic: IDLE -> LAUNCH -> STREAM -> CMPL -> IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
`ifdef HVGEN_WDOG_EN
        wdog_d    = wdog_q;
        err_d     = 1'b0;
        wdog_fire = (wdog_q == WDOG_W'(WDOG_LIM - 1)) && !gen_done;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    len_d   = win_len;
                    grant_d = NUM_REQ'(1) << win_idx;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_STREAM;
`ifdef HVGEN_WDOG_EN
                wdog_d  = '0;
`endif
            end
            ST_STREAM: begin
                if (cnt_q != BEATS) begin
                    cnt_d = cnt_q + 1'b1;
                end
`ifdef HVGEN_WDOG_EN
                wdog_d = wdog_q + 1'b1;
`endif
                if (gen_done) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = ST_CMPL;
                end
`ifdef HVGEN_WDOG_EN
                else if (wdog_fire) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_CMPL;
                end
`endif
            end
            ST_CMPL: begin
                ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
`ifdef HVGEN_WDOG_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
`ifdef HVGEN_WDOG_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    // Beat qualifiers decode from state and counter so they line up with data_stream.
    assign gen_initiate = (state_q == ST_LAUNCH);
    assign grant        = grant_q;
    assign busy         = (state_q != ST_IDLE);
    assign beat_valid   = (state_q == ST_STREAM) && (cnt_q < len_q);
    assign beat_idx     = cnt_q;
    assign beat_last    = beat_valid && (cnt_q == len_q - 1'b1);
    assign cmpl         = (state_q == ST_CMPL) ? (NUM_REQ'(1) << owner_q) : '0;

`ifdef HVGEN_WDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hv_gen_sched.sv
// Testbench for hv_gen_sched with a behavioural LFSR generator attached.
module tb_hv_gen_sched;
    localparam int NUM_REQ = 4;
    localparam int CYCLES  = 7;
    localparam int IDX_W   = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*IDX_W-1:0] req_len;
    logic                     gen_initiate;
    logic                     gen_done;
    logic [NUM_REQ-1:0]       grant;
    logic                     beat_valid;
    logic [IDX_W-1:0]         beat_idx;
    logic                     beat_last;
    logic [NUM_REQ-1:0]       cmpl;
    logic                     busy;
    logic                     err;

    // generator model state
    logic        g_run;
    int          g_k;
    logic [15:0] g_lfsr;
    logic [15:0] data_stream;
    logic        nodone;

    logic [15:0] seq [0:CYCLES];
    int vectors = 0;
    int miscompares = 0;
    int ptr_m = 0;

    hv_gen_sched #(
        .NUM_REQ (NUM_REQ),
        .CYCLES  (CYCLES),
        .IDX_W   (IDX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_len      (req_len),
        .gen_initiate (gen_initiate),
        .gen_done     (gen_done),
        .grant        (grant),
        .beat_valid   (beat_valid),
        .beat_idx     (beat_idx),
        .beat_last    (beat_last),
        .cmpl         (cmpl),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Generator: samples initiate, emits CYCLES+1 beats, pulses done on the last.
    always @(posedge clk) begin
        if (rst) begin
            g_run  <= 1'b0;
            g_k    <= 0;
            g_lfsr <= SEED;
        end else if (gen_initiate) begin
            g_run  <= 1'b1;
            g_k    <= 0;
            g_lfsr <= SEED;
        end else if (g_run) begin
            if (g_k == CYCLES) g_run <= 1'b0;
            else               g_k   <= g_k + 1;
            g_lfsr <= lfsr_next(g_lfsr);
        end
    end
    assign data_stream = g_lfsr;
    assign gen_done    = g_run && (g_k == CYCLES) && !nodone;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_init"},  gen_initiate, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_valid"}, beat_valid, 0);
        chk({tag, "_idx"},   beat_idx, 0);
        chk({tag, "_last"},  beat_last, 0);
        chk({tag, "_cmpl"},  cmpl, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_err"},   err, 0);
    endtask

    task automatic set_lens(input int a, input int b, input int c, input int d);
        req_len = {IDX_W'(d), IDX_W'(c), IDX_W'(b), IDX_W'(a)};
    endtask

    task automatic do_reset(input string tag);
        req = '0;
        rst = 1'b1;
        step();
        check_zero(tag);
        rst = 1'b0;
        step();
        ptr_m = 0;
    endtask

    // Reference arbitration: first set bit at or after the pointer, wrapping.
    function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int o = 0; o < NUM_REQ; o++)
            if (r[(p + o) % NUM_REQ]) return (p + o) % NUM_REQ;
        return -1;
    endfunction

    // One granted run, started from IDLE with req/req_len already applied.
    task automatic serve(input bit drop, input int abort_k, input bit nd);
        int w;
        int len;
        int nst;
        int exp_idx;
        logic [NUM_REQ-1:0] oh;
        logic [NUM_REQ-1:0] rnd;
        w   = pick(req, ptr_m);
        len = int'(req_len[w*IDX_W +: IDX_W]);
        if (len > CYCLES + 1) len = CYCLES + 1;
        oh  = NUM_REQ'(1) << w;
        nodone = nd;
        step();
        chk("launch_init",  gen_initiate, 1);
        chk("launch_grant", grant, oh);
        chk("launch_busy",  busy, 1);
        chk("launch_cmpl",  cmpl, 0);
        chk("launch_valid", beat_valid, 0);
`ifdef HVGEN_WDOG_EN
        nst = nd ? (CYCLES + 2 + 8) : (CYCLES + 1);
`else
        nst = nd ? 30 : (CYCLES + 1);
`endif
        for (int k = 0; k < nst; k++) begin
            step();
            exp_idx = (k > CYCLES + 1) ? CYCLES + 1 : k;
            chk("st_valid", beat_valid, (k < len) ? 1 : 0);
            chk("st_idx",   beat_idx, exp_idx);
            chk("st_last",  beat_last, ((k < len) && (k == len - 1)) ? 1 : 0);
            chk("st_grant", grant, oh);
            chk("st_init",  gen_initiate, 0);
            chk("st_cmpl",  cmpl, 0);
            chk("st_busy",  busy, 1);
            chk("st_err",   err, 0);
            if (k < len) chk("st_data", data_stream, seq[k]);
            if (k == 2) begin
                rnd = NUM_REQ'($urandom_range(0, 15));
                req = drop ? (rnd & ~oh) : (rnd | oh);
                req_len = {IDX_W'($urandom), IDX_W'($urandom), IDX_W'($urandom), IDX_W'($urandom)};
            end
            if (k == abort_k) begin
                req = '0;
                rst = 1'b1;
                step();
                check_zero("abort");
                rst = 1'b0;
                step();
                check_zero("post_abort");
                ptr_m = 0;
                return;
            end
        end
        if (nd) begin
`ifdef HVGEN_WDOG_EN
            step();
            chk("wdog_err",   err, 1);
            chk("wdog_cmpl",  cmpl, oh);
            chk("wdog_grant", grant, 0);
            ptr_m = (w + 1) % NUM_REQ;
            step();
            chk("wdog_idle_busy", busy, 0);
            chk("wdog_idle_err",  err, 0);
`else
            chk("nowdog_busy", busy, 1);
            do_reset("nowdog_reset");
`endif
            nodone = 1'b0;
            return;
        end
        step();
        chk("cmpl_cmpl",  cmpl, oh);
        chk("cmpl_grant", grant, 0);
        chk("cmpl_busy",  busy, 1);
        chk("cmpl_err",   err, 0);
        chk("cmpl_init",  gen_initiate, 0);
        chk("cmpl_valid", beat_valid, 0);
        ptr_m = (w + 1) % NUM_REQ;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_cmpl", cmpl, 0);
        chk("idle_init", gen_initiate, 0);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_len = '0;
        nodone = 1'b0;
        seq[0] = SEED;
        for (int i = 1; i <= CYCLES; i++) seq[i] = lfsr_next(seq[i-1]);

        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        step();
        ptr_m = 0;

        // no requests: stays idle
        repeat (3) begin
            step();
            chk("noreq_busy", busy, 0);
            chk("noreq_init", gen_initiate, 0);
        end

        // single request, full length, over-length
        req = 4'b0001; set_lens(3, 0, 0, 0);   serve(0, -1, 0);
        req = 4'b0001; set_lens(8, 0, 0, 0);   serve(0, -1, 0);
        req = 4'b0001; set_lens(20, 0, 0, 0);  serve(0, -1, 0);

        // round robin from client 0
        do_reset("rr_reset");
        for (int i = 0; i < 5; i++) begin
            req = 4'b1111; set_lens(2, 2, 2, 2);
            chk("rr_order", pick(req, ptr_m), i % NUM_REQ);
            serve(0, -1, 0);
        end

        // zero length with dropped req, dropped req mid-stream
        req = 4'b0010; set_lens(5, 0, 5, 5);  serve(1, -1, 0);
        req = 4'b0100; set_lens(4, 4, 6, 4);  serve(1, -1, 0);

        // randomized runs
        for (int i = 0; i < 8; i++) begin
            req = NUM_REQ'($urandom_range(1, 15));
            set_lens($urandom_range(0, 12), $urandom_range(0, 12),
                     $urandom_range(0, 12), $urandom_range(0, 12));
            serve(bit'($urandom_range(0, 1)), -1, 0);
        end

        // reset on beat 4, then restart from client 0 and SEED
        req = 4'b0100; set_lens(3, 3, 3, 3);  serve(0, -1, 0);
        req = 4'b1000; set_lens(8, 8, 8, 8);  serve(0, 4, 0);
        req = 4'b1001; set_lens(6, 6, 6, 6);
        chk("post_rst_pick", pick(req, ptr_m), 0);
        serve(0, -1, 0);

        // missing gen_done
        req = 4'b0010; set_lens(3, 3, 3, 3);  serve(0, -1, 1);
        req = 4'b0001; set_lens(2, 2, 2, 2);  serve(0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
